// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address, paces instruction
// fetches against memory readiness and datapath stalls, and tracks fetch status.
module pc_sequencer #(
   parameter int            WL       = 32,
   parameter logic [WL-1:0] RESET_PC = '0
) (
   input  logic          CLK,
   input  logic          RSTn,
   input  logic          Stall,
   input  logic [1:0]    PCSrc,
   input  logic          BranchTaken,
   input  logic [WL-1:0] PCBranch,
   input  logic [WL-1:0] JumpTarget,
   input  logic          IMemReady,
   output logic [WL-1:0] PC,
   output logic [WL-1:0] PCPlus4,
   output logic          IMemReq,
   output logic          InstrValid,
   output logic          Redirect,
   output logic          Misaligned,
   output logic [31:0]   FetchCount
);

   typedef enum logic [1:0] {ST_RESET, ST_FETCH, ST_HOLD} state_t;

   state_t        state_q;
   logic [WL-1:0] pc_q;
   logic          redirect_q;
   logic          misaligned_q;
   logic [31:0]   fetch_count_q;

   logic [WL-1:0] next_pc_d;
   logic          target_sel_d;
   logic          load_en_d;

   assign PCPlus4 = pc_q + {{(WL-3){1'b0}}, 3'd4};

   always_comb begin
      next_pc_d    = PCPlus4;
      target_sel_d = 1'b0;
      if (PCSrc == 2'b01 && BranchTaken) begin
         next_pc_d    = PCBranch;
         target_sel_d = 1'b1;
      end else if (PCSrc == 2'b10) begin
         next_pc_d    = JumpTarget;
         target_sel_d = 1'b1;
      end
   end

   // A PC load happens on an accepted, unstalled fetch or when a hold is released.
   assign load_en_d = ((state_q == ST_FETCH) && IMemReady && !Stall) ||
                      ((state_q == ST_HOLD) && !Stall);

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q       <= ST_RESET;
         pc_q          <= RESET_PC;
         redirect_q    <= 1'b0;
         misaligned_q  <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         if (InstrValid)
            fetch_count_q <= fetch_count_q + 32'd1;
         redirect_q <= load_en_d && target_sel_d;
         if (load_en_d) begin
            pc_q <= {next_pc_d[WL-1:2], 2'b00};
            if (target_sel_d && (next_pc_d[1:0] != 2'b00))
               misaligned_q <= 1'b1;
         end
         case (state_q)
            ST_RESET: state_q <= ST_FETCH;
            ST_FETCH: if (IMemReady && Stall) state_q <= ST_HOLD;
            ST_HOLD:  if (!Stall) state_q <= ST_FETCH;
            default:  state_q <= ST_RESET;
         endcase
      end
   end

   // Request is masked while reset is held so nothing is fetched before the first reset edge.
   assign IMemReq    = RSTn && (state_q == ST_FETCH);
   assign InstrValid = IMemReq && IMemReady;
   assign PC         = pc_q;
   assign Redirect   = redirect_q;
   assign Misaligned = misaligned_q;
   assign FetchCount = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a cycle-level reference model.
module tb_pc_sequencer;

   localparam int          WL       = 32;
   localparam logic [31:0] RESET_PC = 32'h0;

   logic          CLK = 1'b0;
   logic          RSTn, Stall, BranchTaken, IMemReady;
   logic [1:0]    PCSrc;
   logic [WL-1:0] PCBranch, JumpTarget;
   logic [WL-1:0] PC, PCPlus4;
   logic          IMemReq, InstrValid, Redirect, Misaligned;
   logic [31:0]   FetchCount;

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase 0 = waiting one cycle after reset, 1 = fetching, 2 = held
   int          m_phase = 0;
   logic [31:0] m_pc, m_cnt;
   logic        m_redir, m_mis;
   bit          m_known = 0;

   pc_sequencer #(.WL(WL), .RESET_PC(RESET_PC)) dut (
      .CLK(CLK), .RSTn(RSTn), .Stall(Stall), .PCSrc(PCSrc),
      .BranchTaken(BranchTaken), .PCBranch(PCBranch), .JumpTarget(JumpTarget),
      .IMemReady(IMemReady), .PC(PC), .PCPlus4(PCPlus4), .IMemReq(IMemReq),
      .InstrValid(InstrValid), .Redirect(Redirect), .Misaligned(Misaligned),
      .FetchCount(FetchCount)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit rstn, input bit stall, input logic [1:0] src, input bit bt,
                      input logic [31:0] pcb, input logic [31:0] jt, input bit ready);
      bit req, load, redirected;
      logic [31:0] target;
      RSTn = rstn; Stall = stall; PCSrc = src; BranchTaken = bt;
      PCBranch = pcb; JumpTarget = jt; IMemReady = ready;
      #1;
      req = rstn && (m_phase == 1);
      check("IMemReq", {31'b0, IMemReq}, {31'b0, req});
      check("InstrValid", {31'b0, InstrValid}, {31'b0, req && ready});
      if (m_known) check("PCPlus4", PCPlus4, m_pc + 32'd4);
      @(posedge CLK);
      if (!rstn) begin
         m_phase = 0; m_pc = RESET_PC; m_redir = 0; m_mis = 0; m_cnt = 0; m_known = 1;
      end else begin
         if (req && ready) m_cnt = m_cnt + 1;
         load = ((m_phase == 1) && ready && !stall) || ((m_phase == 2) && !stall);
         redirected = 1;
         if (src == 2'd1 && bt) target = pcb;
         else if (src == 2'd2) target = jt;
         else begin target = m_pc + 4; redirected = 0; end
         m_redir = load && redirected;
         if (load && redirected && (target % 4 != 0)) m_mis = 1;
         if (load) m_pc = target - (target % 4);
         if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1 && ready && stall) m_phase = 2;
         else if (m_phase == 2 && !stall) m_phase = 1;
      end
      #1;
      check("PC", PC, m_pc);
      check("Redirect", {31'b0, Redirect}, {31'b0, m_redir});
      check("Misaligned", {31'b0, Misaligned}, {31'b0, m_mis});
      check("FetchCount", FetchCount, m_cnt);
      @(negedge CLK);
   endtask

   task automatic seq(input bit stall, input bit ready);
      cyc(1, stall, 2'd0, 0, 32'h0, 32'h0, ready);
   endtask

   task automatic jump(input logic [31:0] t);
      cyc(1, 0, 2'd2, 0, 32'h0, t, 1);
   endtask

   initial begin
      @(negedge CLK);
      // reset for two cycles, then steady sequential fetch
      cyc(0, 0, 2'd0, 0, 0, 0, 1);
      cyc(0, 0, 2'd0, 0, 0, 0, 1);
      check("reset PC", PC, RESET_PC);
      seq(0, 1);                       // leaving reset: no request yet
      for (int i = 0; i < 4; i++) seq(0, 1);
      check("count after 4 fetches", FetchCount, 32'd4);
      check("PC after 4 fetches", PC, 32'h10);
      // taken branch, then not-taken branch from 0x10
      cyc(1, 0, 2'd1, 1, 32'h40, 32'h0, 1);
      check("taken branch PC", PC, 32'h40);
      check("taken branch Redirect", {31'b0, Redirect}, 32'd1);
      seq(0, 1);
      jump(32'h10);
      cyc(1, 0, 2'd1, 0, 32'h40, 32'h0, 1);
      check("not-taken PC", PC, 32'h14);
      check("not-taken Redirect", {31'b0, Redirect}, 32'd0);
      // stall during an accepted fetch at 0x20
      jump(32'h20);
      seq(1, 1);
      seq(1, 1);
      seq(1, 1);
      check("held PC", PC, 32'h20);
      seq(0, 1);
      check("PC after stall release", PC, 32'h24);
      // memory wait at 0x8, including a stall that must be ignored
      jump(32'h8);
      seq(0, 0);
      seq(1, 0);
      seq(0, 0);
      check("PC during wait", PC, 32'h8);
      seq(0, 1);
      check("PC after wait", PC, 32'hC);
      // misaligned jump, sticky flag, and PC wrap
      jump(32'h103);
      check("misaligned jump PC", PC, 32'h100);
      seq(0, 1);
      seq(0, 1);
      check("Misaligned sticky", {31'b0, Misaligned}, 32'd1);
      cyc(1, 0, 2'd3, 1, 32'h0, 32'h0, 1);  // reserved select acts as sequential
      jump(32'hFFFF_FFFC);
      seq(0, 1);
      check("PC wrap", PC, 32'h0);
      // reset while held at 0x30
      jump(32'h30);
      seq(1, 1);
      seq(1, 1);
      cyc(0, 1, 2'd0, 0, 0, 0, 1);
      check("PC after mid-hold reset", PC, RESET_PC);
      check("count after mid-hold reset", FetchCount, 32'd0);
      seq(1, 1);
      seq(0, 1);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, ($urandom_range(0, 3) != 0));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
